// File: rtl/seed_compare_if.sv
// seed_compare_if: memory read ports and match-run counter link of the seed comparator
//   master: tagt_addr/ref_addr/valid/match out, tagt_data/ref_data/hit in
//   slave : mirror of master (memories and counter side)
interface seed_compare_if #(
    parameter int TAGT_LENGTH = 6,
    parameter int REF_LENGTH  = 10
);
    logic [TAGT_LENGTH-1:0] tagt_addr;
    logic [1:0]             tagt_data;
    logic [REF_LENGTH-1:0]  ref_addr;
    logic [1:0]             ref_data;
    logic                   valid;
    logic                   match;
    logic                   hit;
    modport master (output tagt_addr, ref_addr, valid, match, input tagt_data, ref_data, hit);
    modport slave  (input tagt_addr, ref_addr, valid, match, output tagt_data, ref_data, hit);
endinterface

// File: rtl/seed_compare.sv
// seed_compare: serial 2-bit base comparator sliding a target over a reference window
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a search (accepted in IDLE only)
//   bus            : target/reference sync-read ports and counter valid/match/hit
//   busy/done      : search in progress / finished (done held until next start)
//   found/err      : alignment found / counter never confirmed the full run
//   hit_pos        : reference start of the alignment
module seed_compare #(
    parameter int TAGT_NUM    = 64,
    parameter int TAGT_LENGTH = 6,
    parameter int REF_NUM     = 1024,
    parameter int REF_LENGTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    seed_compare_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic                  err,
    output logic [REF_LENGTH-1:0] hit_pos
);
    typedef enum logic [2:0] {IDLE, PRIME, SLOT, GAP, WAIT_HIT, FINISH} state_t;

    localparam logic [REF_LENGTH-1:0]  POS_MAX  = REF_LENGTH'(REF_NUM - TAGT_NUM);
    localparam logic [TAGT_LENGTH-1:0] IDX_MAX  = TAGT_LENGTH'(TAGT_NUM - 1);
    localparam logic [2:0]             WAIT_MAX = 3'd5;

    state_t                 state_q, state_d;
    logic [REF_LENGTH-1:0]  pos_q, pos_d, ref_addr_q, ref_addr_d, hit_pos_q, hit_pos_d;
    logic [TAGT_LENGTH-1:0] idx_q, idx_d, tagt_addr_q, tagt_addr_d;
    logic [2:0]             ph_q, ph_d;
    logic valid_q, valid_d, match_q, match_d, nxt_q, nxt_d;
    logic busy_q, busy_d, done_q, done_d, found_q, found_d, err_q, err_d;
    logic                   eq, last;
    logic [TAGT_LENGTH-1:0] base;

    assign eq = bus.tagt_data == bus.ref_data;
    // base whose slot begins on this edge; its successor's address is issued now
    assign base = state_q == SLOT ? idx_q + TAGT_LENGTH'(1) : idx_q;
    assign last = base == IDX_MAX;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        idx_d       = idx_q;
        ph_d        = ph_q;
        tagt_addr_d = tagt_addr_q;
        ref_addr_d  = ref_addr_q;
        valid_d     = valid_q;
        match_d     = match_q;
        nxt_d       = nxt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        found_d     = found_q;
        err_d       = err_q;
        hit_pos_d   = hit_pos_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = PRIME;
                pos_d       = '0;
                idx_d       = '0;
                ph_d        = '0;
                tagt_addr_d = '0;
                ref_addr_d  = '0;
                busy_d      = 1'b1;
                done_d      = 1'b0;
                found_d     = 1'b0;
                err_d       = 1'b0;
                hit_pos_d   = '0;
            end
            PRIME: if (ph_q == 3'd0) ph_d = 3'd1;
            else begin
                state_d = SLOT;
                ph_d    = '0;
                valid_d = 1'b1;
                match_d = eq;
                if (!last) begin
                    tagt_addr_d = base + TAGT_LENGTH'(1);
                    ref_addr_d  = pos_q + REF_LENGTH'(base) + REF_LENGTH'(1);
                end
            end
            SLOT: begin
                ph_d = ph_q + 3'd1;
                if (ph_q == 3'd1) nxt_d = eq;
                if (ph_q == 3'd2) begin
                    ph_d = '0;
                    if (!match_q) begin
                        state_d = GAP;
                        valid_d = 1'b0;
                    end else if (idx_q == IDX_MAX) state_d = WAIT_HIT;
                    else begin
                        idx_d   = base;
                        match_d = nxt_q;
                        if (!last) begin
                            tagt_addr_d = base + TAGT_LENGTH'(1);
                            ref_addr_d  = pos_q + REF_LENGTH'(base) + REF_LENGTH'(1);
                        end
                    end
                end
            end
            GAP: if (pos_q == POS_MAX) begin
                state_d = FINISH;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d     = PRIME;
                pos_d       = pos_q + REF_LENGTH'(1);
                idx_d       = '0;
                ph_d        = '0;
                tagt_addr_d = '0;
                ref_addr_d  = pos_q + REF_LENGTH'(1);
            end
            WAIT_HIT: begin
                ph_d = ph_q + 3'd1;
                // an unknown hit falls through to the timeout branch
                if (bus.hit) begin
                    state_d   = FINISH;
                    valid_d   = 1'b0;
                    match_d   = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    found_d   = 1'b1;
                    hit_pos_d = pos_q;
                end else if (ph_q == WAIT_MAX) begin
                    state_d = FINISH;
                    valid_d = 1'b0;
                    match_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            idx_q       <= '0;
            ph_q        <= '0;
            tagt_addr_q <= '0;
            ref_addr_q  <= '0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            nxt_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            err_q       <= 1'b0;
            hit_pos_q   <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            idx_q       <= idx_d;
            ph_q        <= ph_d;
            tagt_addr_q <= tagt_addr_d;
            ref_addr_q  <= ref_addr_d;
            valid_q     <= valid_d;
            match_q     <= match_d;
            nxt_q       <= nxt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            err_q       <= err_d;
            hit_pos_q   <= hit_pos_d;
        end
    end

    assign bus.tagt_addr = tagt_addr_q;
    assign bus.ref_addr  = ref_addr_q;
    assign bus.valid     = valid_q;
    assign bus.match     = match_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign found         = found_q;
    assign err           = err_q;
    assign hit_pos       = hit_pos_q;
endmodule

// File: doc/seed_compare.md
# seed_compare

Serial base comparator sitting directly upstream of the match-run counter in the BWT alignment path. It walks a candidate window of the reference memory against the full target sequence, one 2-bit base per 3-cycle slot, and drives the counter's `valid`/`in` pair (here `valid`/`match`). It then watches the counter's `en2` (here `hit`) to declare an alignment, and otherwise slides the window by one reference position until the reference is exhausted.

## Interface
- `TAGT_NUM`, 64, number of target bases
- `TAGT_LENGTH`, 6, target address width
- `REF_NUM`, 1024, number of reference bases
- `REF_LENGTH`, 10, reference address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin search; sampled only in IDLE
- `tagt_addr`  out  TAGT_LENGTH  target memory read address
- `tagt_data`  in  2  target base, sync read, valid 1 cycle after address
- `ref_addr`  out  REF_LENGTH  reference memory read address
- `ref_data`  in  2  reference base, sync read, valid 1 cycle after address
- `valid`  out  1  to counter; low clears counter
- `match`  out  1  to counter `in`; per-base compare result, held 3 cycles
- `hit`  in  1  from counter `en2`; only sampled in WAIT_HIT, non-1 treated as 0
- `busy`  out  1  search in progress
- `done`  out  1  search finished; level, held until next accepted `start`
- `found`  out  1  with `done`: alignment found
- `err`  out  1  with `done`: counter never confirmed a full run
- `hit_pos`  out  REF_LENGTH  reference start of alignment when `found`

## Operation
- Reset: all outputs 0, addresses 0, state IDLE, `pos`=0, `idx`=0.
- States: IDLE, PRIME, SLOT, GAP, WAIT_HIT, FINISH.
- IDLE: on `start`=1, clear `done`/`found`/`err`/`hit_pos`, set `pos`=0, `idx`=0, `busy`=1, go PRIME. `start` in any other state is ignored.
- PRIME (2 cycles, `valid`=0):
  - cycle 1 issues `tagt_addr`=0, `ref_addr`=`pos`.
  - cycle 2 captures data, compares, and loads `match`, then enters SLOT.
- SLOT (3 cycles per base, phase counter 0..2, `valid`=1):
  - `match` holds the result for base `idx` for all 3 cycles.
  - phase 0 issues addresses for `idx+1` (`ref_addr`=`pos+idx+1`).
  - phase 1 captures the data.
  - phase 2 edge advances the state:
    - `match`=0 → GAP;
    - `idx`=TAGT_NUM-1 → WAIT_HIT with `match`=1;
    - otherwise `idx`+1 and `match` loaded with the next result.
- GAP (1 cycle, `valid`=0, `match`=0):
  - if `pos`=REF_NUM-TAGT_NUM → FINISH with `found`=0, `err`=0;
  - otherwise `pos`+1, `idx`=0 → PRIME.
- WAIT_HIT (max 6 cycles, `valid`=1, `match`=1):
  - `hit`=1 → FINISH with `found`=1, `hit_pos`=`pos`;
  - timeout → FINISH with `err`=1.
- FINISH (1 cycle): `valid`=0, `match`=0, `busy`=0, `done`=1 → IDLE.
- Arithmetic: `pos+idx` is REF_LENGTH wide and never wraps, since `pos` ≤ REF_NUM-TAGT_NUM. `idx` is TAGT_LENGTH wide; TAGT_NUM must be ≤ 2^TAGT_LENGTH.
- Mismatch on the last base behaves like any mismatch (GAP), not WAIT_HIT.

## Timing
- `valid` rises on the same edge that first loads `match` for base 0. This aligns the counter's 3-cycle phase with slot phase 0.
- Any `valid`=0 cycle resets the counter. Every candidate restart has `valid` low for 3 cycles (GAP + PRIME).
- Full match at a candidate: 2 + 3·TAGT_NUM cycles of valid data, then `hit` is expected within 2 slots. The counter raises `en2` at the end of the slot after the last one counted.
- Mismatch at base k: the candidate costs 2 + 3(k+1) + 1 cycles.
- `done`/`found`/`hit_pos` are valid from the FINISH edge and hold until the next `start`.
- `rst_n` low mid-search: immediate return to reset values. No `done` is produced, and `valid`=0 clears the counter.

## Test plan
- TAGT_NUM=4, REF_NUM=16, target ACGT at ref 0, counter model attached:
  - `valid` high 14 cycles;
  - `hit` follows;
  - `done`=1, `found`=1, `hit_pos`=0.
- Same target placed at ref 5, other bases mismatched:
  - exactly 5 GAP visits, each with `valid` low 3 cycles;
  - `hit_pos`=5.
- Target absent from the reference:
  - `pos` stops at 12 (REF_NUM-TAGT_NUM);
  - `done`=1, `found`=0, `err`=0, `busy`=0.
- Full match with `hit` tied 0:
  - `match`=1 held 6 cycles in WAIT_HIT;
  - then `done`=1, `err`=1.
- `rst_n` pulsed low during SLOT at idx 2:
  - all outputs 0 on the next sample;
  - a new `start` reruns from `pos`=0.
- `start` held high through an entire search:
  - exactly one search per accepted `start`;
  - mismatch on last base (idx 3) → GAP, not WAIT_HIT.
